// File: rtl/csa_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csa_accum_ctrl / carrysaveadder                                            |
// | Accumulates num_ops operands in carry-save form, then resolves once.       |
// | Optional macro: CSA_ACC_ABORT_EN (adds the abort port).                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+

module carrysaveadder #(
   parameter int WIDTH = 14
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);
   assign sum      = a ^ b ^ c;
   assign carry[0] = 1'b0;

   // carry is pre-shifted; the majority of the top bit has no home and is dropped
   generate
      for (genvar i = 1; i < WIDTH; i++) begin : g_carry
         assign carry[i] = (a[i-1] & b[i-1]) | (a[i-1] & c[i-1]) | (b[i-1] & c[i-1]);
      end
   endgenerate
endmodule

module csa_accum_ctrl #(
   parameter int WIDTH = 10,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CNT_W-1:0]       num_ops,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH+CNT_W-1:0] result,
   output logic                   out_valid,
   input  logic                   out_ready,
`ifdef CSA_ACC_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   busy
);
   localparam int ACC_W = WIDTH + CNT_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_RESOLVE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_remaining;
   logic [ACC_W-1:0]   r_sum;
   logic [ACC_W-1:0]   r_carry;
   logic [ACC_W-1:0]   r_result;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [ACC_W-1:0]   w_operand;
   logic [ACC_W-1:0]   w_csa_sum;
   logic [ACC_W-1:0]   w_csa_carry;

   assign w_operand = {{CNT_W{1'b0}}, in_data};

   carrysaveadder #(.WIDTH(ACC_W)) u_csa (
      .a     (r_sum),
      .b     (r_carry),
      .c     (w_operand),
      .sum   (w_csa_sum),
      .carry (w_csa_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_sum       <= '0;
         r_carry     <= '0;
         r_result    <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef CSA_ACC_ABORT_EN
      end else if (abort && (r_state != S_IDLE)) begin
         // result deliberately keeps the previous job's value
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_sum       <= '0;
         r_carry     <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_remaining <= num_ops;
                  r_sum       <= '0;
                  r_carry     <= '0;
                  r_busy      <= 1'b1;
                  if (num_ops != '0) begin
                     r_state    <= S_ACCUM;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state    <= S_RESOLVE;
                  end
               end
            end
            S_ACCUM: begin
               if (in_valid && r_in_ready) begin
                  r_sum       <= w_csa_sum;
                  r_carry     <= w_csa_carry;
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == CNT_W'(1)) begin
                     r_state    <= S_RESOLVE;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            S_RESOLVE: begin
               r_result    <= r_sum + r_carry;
               r_state     <= S_DONE;
               r_out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign result    = r_result;
endmodule
`default_nettype wire
